// File: rtl/pb_interval_timer_pkg.sv
// Shared constants for the PacoBlaze interval timer.
// Covers the port-bus width, register offsets and CTRL bit positions.
package pb_interval_timer_pkg;

  localparam int unsigned OperandWidth = 8;

  localparam logic [1:0] OffCtrl     = 2'd0;
  localparam logic [1:0] OffReloadLo = 2'd1;
  localparam logic [1:0] OffReloadHi = 2'd2;
  localparam logic [1:0] OffTicks    = 2'd3;

  localparam int unsigned CtrlEn   = 0;
  localparam int unsigned CtrlIe   = 1;
  localparam int unsigned CtrlAr   = 2;
  localparam int unsigned CtrlPend = 7;

  function automatic logic [OperandWidth-1:0] ctrl_pack(logic en, logic ie, logic ar, logic pend);
    logic [OperandWidth-1:0] v;
    v           = '0;
    v[CtrlEn]   = en;
    v[CtrlIe]   = ie;
    v[CtrlAr]   = ar;
    v[CtrlPend] = pend;
    return v;
  endfunction

endpackage

// File: rtl/pb_interval_timer_core.sv
// Prescale down-counter: loads on start, counts while running,
// and flags expiry when it is running at zero.
module pb_interval_timer_core #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             run,
  input  logic [Width-1:0] reload,
  output logic             expire
);

  logic [Width-1:0] pcnt_q, pcnt_d;

  always_comb begin
    expire = run && (pcnt_q == '0);
    pcnt_d = pcnt_q;
    if (load) begin
      pcnt_d = reload;
    end else if (run) begin
      pcnt_d = (pcnt_q == '0) ? reload : pcnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/pb_interval_timer.sv
// Port-mapped interval timer for the PacoBlaze I/O bus: register file,
// address decode, registered read mux and level interrupt.
module pb_interval_timer
  import pb_interval_timer_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR      = 8'h10,
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              port_id,
  input  logic [OperandWidth-1:0] out_port,
  input  logic                    write_strobe,
  input  logic                    read_strobe,
  output logic [OperandWidth-1:0] in_port,
  output logic                    interrupt,
  input  logic                    interrupt_ack,
  output logic                    tick
);

  logic                      en_q, en_d, ie_q, ie_d, ar_q, ar_d, pend_q, pend_d;
  logic [PRESCALE_WIDTH-1:0] reload_q, reload_d;
  logic [7:0]                ticks_q, ticks_d;
  logic [OperandWidth-1:0]   in_port_q, in_port_d;
  logic                      irq_q, tick_q;
  logic                      sel, wr_ctrl, wr_lo, wr_hi, wr_ticks;
  logic                      run, load, expire;

  // read_strobe is not needed: the read mux is refreshed every cycle.
  logic unused_read_strobe;
  assign unused_read_strobe = read_strobe;

  assign sel      = (port_id[7:2] == BASE_ADDR[7:2]);
  assign wr_ctrl  = write_strobe && sel && (port_id[1:0] == OffCtrl);
  assign wr_lo    = write_strobe && sel && (port_id[1:0] == OffReloadLo);
  assign wr_hi    = write_strobe && sel && (port_id[1:0] == OffReloadHi);
  assign wr_ticks = write_strobe && sel && (port_id[1:0] == OffTicks);

  // A CTRL write clearing EN stops the counter before it can expire this cycle.
  assign run  = en_q && !(wr_ctrl && !out_port[CtrlEn]);
  assign load = wr_ctrl && out_port[CtrlEn] && !en_q;

  pb_interval_timer_core #(
    .Width(PRESCALE_WIDTH)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .run   (run),
    .reload(reload_q),
    .expire(expire)
  );

  always_comb begin
    en_d     = en_q;
    ie_d     = ie_q;
    ar_d     = ar_q;
    reload_d = reload_q;
    if (wr_ctrl) begin
      en_d = out_port[CtrlEn];
      ie_d = out_port[CtrlIe];
      ar_d = out_port[CtrlAr];
    end else if (expire && !ar_q) begin
      en_d = 1'b0;
    end
    if (wr_lo) reload_d[7:0]  = out_port;
    if (wr_hi) reload_d[15:8] = out_port;

    pend_d = pend_q;
    if (interrupt_ack || (wr_ctrl && out_port[CtrlPend])) pend_d = 1'b0;
    if (expire && ie_q) pend_d = 1'b1;

    ticks_d = ticks_q;
    if (wr_ticks) begin
      ticks_d = '0;
    end else if (expire) begin
      ticks_d = ticks_q + 8'd1;
    end

    in_port_d = '0;
    if (sel) begin
      case (port_id[1:0])
        OffCtrl:     in_port_d = ctrl_pack(en_q, ie_q, ar_q, pend_q);
        OffReloadLo: in_port_d = reload_q[7:0];
        OffReloadHi: in_port_d = reload_q[15:8];
        default:     in_port_d = ticks_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q      <= 1'b0;
      ie_q      <= 1'b0;
      ar_q      <= 1'b0;
      pend_q    <= 1'b0;
      reload_q  <= '0;
      ticks_q   <= '0;
      in_port_q <= '0;
      irq_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      en_q      <= en_d;
      ie_q      <= ie_d;
      ar_q      <= ar_d;
      pend_q    <= pend_d;
      reload_q  <= reload_d;
      ticks_q   <= ticks_d;
      in_port_q <= in_port_d;
      irq_q     <= pend_q && ie_q;
      tick_q    <= expire;
    end
  end

  assign in_port   = in_port_q;
  assign interrupt = irq_q;
  assign tick      = tick_q;

endmodule
